// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator: holds the fetch PC, sequences it by +4 and
// applies redirects from decode, including redirects that arrive while the
// fetch stage is stalled (kept pending until the stall clears).
// Ports: clk/rst (sync, active-high), stall (bit 0 freezes fetch),
//        br_bus {br_e, br_addr}, if_to_id_bus {ce, pc}, inst_sram_* SRAM
//        read port (never writes), if_adel (misaligned fetch flag).
// Optional feature: define IF_ADEL_CHECK_EN to flag misaligned fetch PCs and
// suppress the SRAM read for them; otherwise if_adel is tied low.
// Latency: one cycle from br_e (sampled unstalled) to the new PC on
// inst_sram_addr; SRAM data follows one cycle later.
// Backpressure: stall[0]=1 holds pc/ce; a redirect seen while stalled is
// remembered (newest wins) and applied on the first unstalled edge.
module if_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          STALL_WD = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_WD-1:0] stall,
    input  logic [32:0]         br_bus,
    output logic [32:0]         if_to_id_bus,
    output logic                inst_sram_en,
    output logic [3:0]          inst_sram_wen,
    output logic [31:0]         inst_sram_addr,
    output logic [31:0]         inst_sram_wdata,
    output logic                if_adel
);

    // The register sits one word below RESET_PC so the first unstalled
    // edge lands on RESET_PC through the ordinary +4 path.
    localparam logic [31:0] RESET_PC_M4 = RESET_PC - 32'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic        r_pend_v;
    logic [31:0] r_pend_addr;

    logic        w_stop;
    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic [31:0] w_next_pc;
    logic        w_ce;

    // Only bit 0 of the stall vector concerns the fetch stage.
    logic        w_unused_stall;
    assign w_unused_stall = &{1'b0, stall[STALL_WD-1:1]};

    assign w_stop    = stall[0];
    assign w_br_e    = br_bus[32];
    assign w_br_addr = br_bus[31:0];
    assign w_ce      = (r_state == RUN);

    // Live redirect beats a pending one; sequential fetch wraps mod 2^32.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (w_br_e)
            w_next_pc = w_br_addr;
        else if (r_pend_v)
            w_next_pc = r_pend_addr;
    end

    // IDLE only until the first unstalled edge; RUN is left only by reset.
    always_comb begin
        w_state_nxt = r_state;
        if (!w_stop)
            w_state_nxt = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC_M4;
            r_pend_v    <= 1'b0;
            r_pend_addr <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_stop) begin
                r_pc     <= w_next_pc;
                r_pend_v <= 1'b0;
            end else if (w_br_e) begin
                r_pend_v    <= 1'b1;
                r_pend_addr <= w_br_addr;
            end
        end
    end

    assign if_to_id_bus    = {w_ce, r_pc};
    assign inst_sram_addr  = r_pc;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0;

`ifdef IF_ADEL_CHECK_EN
    // Misaligned PC: flag it for the exception path and skip the SRAM read;
    // sequencing continues from the misaligned value unchanged.
    assign if_adel      = w_ce & (r_pc[1:0] != 2'b00);
    assign inst_sram_en = w_ce & ~if_adel;
`else
    assign if_adel      = 1'b0;
    assign inst_sram_en = w_ce;
`endif

endmodule

// File: doc/if_pc_gen.md
IF_PC_GEN -- requirements
Module: if_pc_gen

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'hBFC0_0000, meaning the address of the first instruction fetched after reset.
REQ-002 The block SHALL have parameter STALL_WD, default 6, meaning the width of the pipeline stall vector.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port stall  input  STALL_WD  pipeline stall vector; bit 0 = 1 (Stop) freezes the fetch stage.
REQ-006 The block SHALL have port br_bus  input  33  redirect request from decode, {br_e[32], br_addr[31:0]}.
REQ-007 The block SHALL have port if_to_id_bus  output  33  fetch tag to decode, {ce[32], pc[31:0]}.
REQ-008 The block SHALL have port inst_sram_en  output  1  instruction SRAM read enable.
REQ-009 The block SHALL have port inst_sram_wen  output  4  instruction SRAM byte write enables; always 4'b0000.
REQ-010 The block SHALL have port inst_sram_addr  output  32  instruction SRAM byte address.
REQ-011 The block SHALL have port inst_sram_wdata  output  32  instruction SRAM write data; always 32'h0.
REQ-012 The block SHALL have port if_adel  output  1  fetch address error flag for the current pc.

Function
REQ-013 State SHALL be pc_reg[31:0], ce_reg, pend_v, and pend_addr[31:0].
REQ-014 The outputs SHALL be if_to_id_bus = {ce_reg, pc_reg} and inst_sram_addr = pc_reg, both combinational from state.
REQ-015 inst_sram_en SHALL equal ce_reg, gated by REQ-027 when that requirement applies.
REQ-016 next_pc SHALL be br_addr if br_e=1, else pend_addr if pend_v=1, else pc_reg+4, with priority in that order.
REQ-017 pc_reg+4 SHALL be computed mod 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-018 When stall[0]=0, at each clk edge pc_reg SHALL load next_pc, ce_reg SHALL load 1, and pend_v SHALL clear.
REQ-019 When stall[0]=1, pc_reg and ce_reg SHALL hold.
REQ-020 When stall[0]=1 and br_e=1, pend_v SHALL be set and pend_addr SHALL load br_addr.
REQ-021 When stall[0]=1 and br_e=1 while pend_v is already set, the newer br_addr SHALL overwrite pend_addr.
REQ-022 When stall[0]=1 and br_e=0, pend_v and pend_addr SHALL hold.
REQ-023 Fetch latency SHALL be one cycle: the SRAM data for inst_sram_addr returns on the next cycle, aligned with decode's registered copy of if_to_id_bus.
REQ-024 A redirect SHALL take effect on the cycle after br_e is sampled with stall[0]=0; the instruction already fetched that cycle (the delay slot) SHALL NOT be cancelled.
REQ-025 The block SHALL have exactly two effective states:
  - IDLE (ce_reg=0), entered on reset.
  - RUN (ce_reg=1).
  IDLE SHALL go to RUN on the first clk edge with stall[0]=0; RUN SHALL be left only via rst.

Reset
REQ-026 On any clk edge with rst=1, regardless of stall or br_bus, the block SHALL set:
  - pc_reg = RESET_PC-4;
  - ce_reg = 0, pend_v = 0, pend_addr = 0.
  Resulting outputs: inst_sram_en=0, if_to_id_bus={1'b0, RESET_PC-4}, if_adel=0. Reset mid-stall SHALL discard any pending redirect.

Configuration
REQ-027 With macro IF_ADEL_CHECK_EN defined, if_adel SHALL be ce_reg & (pc_reg[1:0]!=2'b00), and inst_sram_en SHALL be forced to 0 while if_adel=1; pc sequencing SHALL be unaffected.
REQ-028 With IF_ADEL_CHECK_EN undefined, if_adel SHALL be constant 0 and inst_sram_en SHALL equal ce_reg.

Verification
REQ-029 Scenario: hold rst 2 cycles, then release with stall=0 -> inst_sram_addr sequence BFBF_FFFC (en=0), BFC0_0000, BFC0_0004, BFC0_0008 (en=1).
REQ-030 Scenario: br_e=1, br_addr=8000_0100 for one cycle at pc BFC0_0008 -> next addresses 8000_0100, 8000_0104.
REQ-031 Scenario: stall[0]=1 for 3 cycles at pc BFC0_0010, with br_e=1/8000_0200 pulsed in stall cycle 2 -> pc holds BFC0_0010; first unstalled cycle gives 8000_0200; pend_v clears.
REQ-032 Scenario: two redirects during one stall (8000_0300, then 8000_0400) -> pc resumes at 8000_0400.
REQ-033 Scenario: pc forced to FFFF_FFFC via br_addr -> next address 0000_0000; rst asserted while pend_v=1 -> pc BFBF_FFFC, pend_v=0.
REQ-034 Scenario: IF_ADEL_CHECK_EN defined, br_addr=8000_0102 -> if_adel=1 and inst_sram_en=0 at that pc; next pc 8000_0106. With the macro undefined, the same stimulus gives if_adel=0 and en=1.
